// File: rtl/apb_i2c_regs.sv
// -----------------------------------------------------------------------------
// apb_i2c_regs
//
// APB3 register front-end for the I2C master controller. It holds the TX FIFO
// ({last, byte}) that the controller drains and the RX FIFO that the
// controller fills. It also holds the SCL divider, and it collects the
// controller's event pulses into sticky interrupt status with a registered
// level interrupt.
//
// Build option: define APB_I2C_PSLVERR_EN to drive pslverr on bad accesses.
// Without it, pslverr is tied low and all other behaviour is the same.
//
// APB handshake:
//   setup  = psel & ~penable
//   access = psel &  penable
//   The slave has zero wait states, so pready is always 1.
//   Writes commit on the edge that ends the access cycle.
//   Read data is registered on the edge that ends the setup cycle, so it is
//   stable during the access cycle.
//   An RX_DATA read pops the RX FIFO on that same setup edge.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   paddr/psel/penable/pwrite/pwdata -> APB request
//   pready/prdata/pslverr    <- APB response
//   i2c_scl_div_rate         SCL divider to the controller
//   tx_fifo_ren/empty/dout/dout_last  TX FIFO controller side (non-FWFT)
//   rx_fifo_wen/full/din     RX FIFO controller side
//   i2c_tx_done, i2c_rx_done, i2c_slave_resp_err, i2c_rx_overflow  event pulses
//   i2c_tx_bytes_n, i2c_rx_bytes_n  byte counts captured on the done pulses
//   irq                      registered level interrupt
//
// Register map (word offsets):
//   0x00 TX_DATA  W    push {pwdata[8], pwdata[7:0]}; reads 0
//   0x04 RX_DATA  R    {valid, 23'b0, byte}
//   0x08 STATUS   R    [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full
//                      [8 +: LW] tx_level [20 +: LW] rx_level
//   0x0C CTRL     RW   [7:0] divider; a write of 0 is stored as 1
//   0x10 INT_STS  W1C  [4:0] flags, [11:8] tx bytes, [15:12] rx bytes
//   0x14 INT_EN   RW   [4:0]
// -----------------------------------------------------------------------------
module apb_i2c_regs #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_RST    = 49
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [5:0]  paddr,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr,
   output logic [7:0]  i2c_scl_div_rate,
   input  logic        tx_fifo_ren,
   output logic        tx_fifo_empty,
   output logic [7:0]  tx_fifo_dout,
   output logic        tx_fifo_dout_last,
   input  logic        rx_fifo_wen,
   output logic        rx_fifo_full,
   input  logic [7:0]  rx_fifo_din,
   input  logic        i2c_tx_done,
   input  logic        i2c_rx_done,
   input  logic        i2c_slave_resp_err,
   input  logic        i2c_rx_overflow,
   input  logic [3:0]  i2c_tx_bytes_n,
   input  logic [3:0]  i2c_rx_bytes_n,
   output logic        irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = LW - 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   logic          setup, access;
   logic [3:0]    addr;
   logic          unused_bits;

   // Pointers carry one extra bit so that full and empty are distinguishable.
   logic [8:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [LW-1:0] tx_wr, tx_rd, tx_level;
   logic [LW-1:0] rx_wr, rx_rd, rx_level;
   logic          tx_full, rx_empty;
   logic          tx_push, tx_pop, rx_push, rx_pop, tx_ovf_ev;

   logic [4:0]    int_sts, int_en, sts_set, sts_clr;
   logic [3:0]    tx_cnt, rx_cnt;
   logic [31:0]   rdata;

   assign setup       = psel & ~penable;
   assign access      = psel & penable;
   assign addr        = paddr[5:2];
   assign pready      = 1'b1;
   assign unused_bits = ^{paddr[1:0], pwdata[31:9]};

   assign tx_level      = tx_wr - tx_rd;
   assign rx_level      = rx_wr - rx_rd;
   assign tx_fifo_empty = (tx_level == '0);
   assign tx_full       = (tx_level == FULL_LVL);
   assign rx_empty      = (rx_level == '0);
   assign rx_fifo_full  = (rx_level == FULL_LVL);

   // Full is judged before any same-cycle pop, so a push to a full FIFO drops.
   assign tx_push   = access & pwrite & (addr == 4'h0) & ~tx_full;
   assign tx_ovf_ev = access & pwrite & (addr == 4'h0) &  tx_full;
   assign tx_pop    = tx_fifo_ren & ~tx_fifo_empty;
   assign rx_push   = rx_fifo_wen & ~rx_fifo_full;
   assign rx_pop    = setup & ~pwrite & (addr == 4'h1) & ~rx_empty;

   assign sts_set = {tx_ovf_ev, i2c_rx_overflow, i2c_slave_resp_err, i2c_rx_done, i2c_tx_done};
   assign sts_clr = (access && pwrite && addr == 4'h4) ? pwdata[4:0] : 5'd0;

   always_comb begin
      rdata = '0;
      case (addr)
         4'h1: if (!rx_empty) rdata = {1'b1, 23'd0, rx_mem[rx_rd[AW-1:0]]};
         4'h2: begin
            rdata[0]         = tx_fifo_empty;
            rdata[1]         = tx_full;
            rdata[2]         = rx_empty;
            rdata[3]         = rx_fifo_full;
            rdata[8 +: LW]   = tx_level;
            rdata[20 +: LW]  = rx_level;
         end
         4'h3: rdata = {24'd0, i2c_scl_div_rate};
         4'h4: rdata = {16'd0, rx_cnt, tx_cnt, 3'd0, int_sts};
         4'h5: rdata = {27'd0, int_en};
         default: rdata = '0;
      endcase
   end

   // The storage arrays need no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr[AW-1:0]] <= pwdata[8:0];
      if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_fifo_din;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_wr             <= '0;
         tx_rd             <= '0;
         rx_wr             <= '0;
         rx_rd             <= '0;
         tx_fifo_dout      <= '0;
         tx_fifo_dout_last <= 1'b0;
         prdata            <= '0;
         i2c_scl_div_rate  <= 8'(DIV_RST);
         int_sts           <= '0;
         int_en            <= '0;
         tx_cnt            <= '0;
         rx_cnt            <= '0;
         irq               <= 1'b0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop) begin
            tx_rd             <= tx_rd + 1'b1;
            tx_fifo_dout      <= tx_mem[tx_rd[AW-1:0]][7:0];
            tx_fifo_dout_last <= tx_mem[tx_rd[AW-1:0]][8];
         end
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;

         prdata <= (setup && !pwrite) ? rdata : '0;

         if (access && pwrite && addr == 4'h3)
            i2c_scl_div_rate <= (pwdata[7:0] == 8'd0) ? 8'd1 : pwdata[7:0];
         if (access && pwrite && addr == 4'h5)
            int_en <= pwdata[4:0];

         // The set term is ORed in after the clear, so a same-cycle event wins.
         int_sts <= (int_sts & ~sts_clr) | sts_set;
         if (i2c_tx_done) tx_cnt <= i2c_tx_bytes_n;
         if (i2c_rx_done) rx_cnt <= i2c_rx_bytes_n;

         irq <= |(int_sts & int_en);
      end
   end

`ifdef APB_I2C_PSLVERR_EN
   // This flag remembers whether the RX FIFO was empty when the read was set up.
   logic rd_empty_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    rd_empty_q <= 1'b0;
      else if (setup) rd_empty_q <= rx_empty;
   end

   always_comb begin
      pslverr = 1'b0;
      if (access) begin
         if (addr > 4'h5)                              pslverr = 1'b1;
         if (pwrite && addr == 4'h0 && tx_full)        pslverr = 1'b1;
         if (pwrite && (addr == 4'h1 || addr == 4'h2)) pslverr = 1'b1;
         if (!pwrite && addr == 4'h1 && rd_empty_q)    pslverr = 1'b1;
      end
   end
`else
   assign pslverr = 1'b0;
`endif

endmodule
